// File: rtl/transport_arbiter.sv
// Two-way round-robin arbiter for the shared transport resource: registered one-hot grants,
// each held at most MAX_HOLD cycles and followed by GAP forced idle cycles.
module transport_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int GAP      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_req,
  input  logic train_req,
  input  logic bus_done,
  input  logic train_done,
  output logic bus_gnt,
  output logic train_gnt,
  output logic transport,
  output logic last_owner
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_TRAIN, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ptr_q, ptr_d;    // 0 = bus has priority on a tie
  logic          last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      ptr_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        hold_d = '0;
        gap_d  = '0;
        if (bus_req && train_req) state_d = ptr_q ? S_TRAIN : S_BUS;
        else if (bus_req)         state_d = S_BUS;
        else if (train_req)       state_d = S_TRAIN;
      end
      S_BUS: begin
        if (!bus_req || bus_done || hold_q == HW'(MAX_HOLD - 1)) begin
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
          hold_d  = '0;
          last_d  = 1'b0;
          ptr_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_TRAIN: begin
        if (!train_req || train_done || hold_q == HW'(MAX_HOLD - 1)) begin
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
          hold_d  = '0;
          last_d  = 1'b1;
          ptr_d   = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        // Requests seen here are deliberately ignored until IDLE.
        if (gap_q == GW'(GAP - 1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  assign bus_gnt    = (state_q == S_BUS);
  assign train_gnt  = (state_q == S_TRAIN);
  assign transport  = bus_gnt | train_gnt;
  assign last_owner = last_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) !(bus_gnt && train_gnt));
  a_busy:   assert property (@(posedge clk) transport == (bus_gnt | train_gnt));
  a_bus_rq: assert property (@(posedge clk) disable iff (rst) $rose(bus_gnt) |-> $past(bus_req));
  a_trn_rq: assert property (@(posedge clk) disable iff (rst) $rose(train_gnt) |-> $past(train_req));

endmodule
